// File: rtl/mux_4x1.sv
// mux_4x1: registered 4-to-1 selector; {s1,s0} picks i0..i3 (WIDTH bits each), r is that word one clk later, cleared asynchronously while rst_n is low
module mux_4x1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [WIDTH-1:0] r
);
  logic [WIDTH-1:0] sel_d;
  always_comb sel_d = s1 ? (s0 ? i3 : i2) : (s0 ? i1 : i0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r <= '0;
    else r <= sel_d;
endmodule

// File: tb/tb_mux_4x1.sv
// tb_mux_4x1: self-checking bench for mux_4x1 at WIDTH=1 and WIDTH=8
module tb_mux_4x1;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic s0 = 1'b0, s1 = 1'b0, i0 = 1'b0, i1 = 1'b0, i2 = 1'b0, i3 = 1'b0;
  logic r;
  logic w_s0 = 1'b0, w_s1 = 1'b0;
  logic [7:0] w_i0 = '0, w_i1 = '0, w_i2 = '0, w_i3 = '0;
  logic [7:0] w_r;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux_4x1 #(.WIDTH(1)) dut (
    .clk(clk), .rst_n(rst_n), .s0(s0), .s1(s1),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3), .r(r)
  );

  mux_4x1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .s0(w_s0), .s1(w_s1),
    .i0(w_i0), .i1(w_i1), .i2(w_i2), .i3(w_i3), .r(w_r)
  );

  task automatic test_reset();
    #1;
    rst_n = 1'b0;
    {s1, s0} = 2'b00;
    {i3, i2, i1, i0} = 4'b0001;
    #1;
    n_tests++;
    if (r !== 1'b0) begin n_fail++; $display("FAIL reset_async r=%b exp=0", r); end
    n_tests++;
    if (w_r !== 8'h00) begin n_fail++; $display("FAIL reset_async_w8 r=%h exp=00", w_r); end
    repeat (3) begin
      @(posedge clk); #1;
      n_tests++;
      if (r !== 1'b0) begin n_fail++; $display("FAIL reset_hold r=%b exp=0", r); end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (r !== 1'b1) begin n_fail++; $display("FAIL reset_release r=%b exp=1", r); end
  endtask

  task automatic test_walking();
    for (int k = 0; k < 4; k++) begin
      logic [3:0] d;
      logic [1:0] sk;
      d = 4'b0001 << k;
      sk = 2'(k);
      {s1, s0} = sk;
      {i3, i2, i1, i0} = d;
      @(posedge clk); #1;
      n_tests++;
      if (r !== 1'b1) begin n_fail++; $display("FAIL walking sel=%0d r=%b exp=1", k, r); end
    end
  endtask

  task automatic test_unselected();
    {i3, i2, i1, i0} = 4'b1000;
    {s1, s0} = 2'b11;
    @(posedge clk); #1;
    n_tests++;
    if (r !== 1'b1) begin n_fail++; $display("FAIL unsel_sel3 r=%b exp=1", r); end
    {s1, s0} = 2'b10;
    @(posedge clk); #1;
    n_tests++;
    if (r !== 1'b0) begin n_fail++; $display("FAIL unsel_sel2 r=%b exp=0", r); end
  endtask

  task automatic test_exhaustive();
    for (int v = 0; v < 64; v++) begin
      logic [5:0] pat;
      logic [3:0] ins;
      logic exp;
      pat = 6'(v);
      ins = pat[3:0];
      exp = ins[pat[5:4]];
      {s1, s0, i3, i2, i1, i0} = pat;
      @(posedge clk); #1;
      n_tests++;
      if (r !== exp) begin n_fail++; $display("FAIL exhaustive pat=%b r=%b exp=%b", pat, r, exp); end
    end
  endtask

  task automatic test_mid_reset();
    {s1, s0} = 2'b11;
    {i3, i2, i1, i0} = 4'b1000;
    @(posedge clk); #1;
    n_tests++;
    if (r !== 1'b1) begin n_fail++; $display("FAIL midrst_pre r=%b exp=1", r); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (r !== 1'b0) begin n_fail++; $display("FAIL midrst_clear r=%b exp=0", r); end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (r !== 1'b0) begin n_fail++; $display("FAIL midrst_lost r=%b exp=0", r); end
    @(posedge clk); #1;
    n_tests++;
    if (r !== 1'b1) begin n_fail++; $display("FAIL midrst_recover r=%b exp=1", r); end
  endtask

  task automatic test_wide();
    logic [7:0] words [4];
    words = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    w_i0 = words[0]; w_i1 = words[1]; w_i2 = words[2]; w_i3 = words[3];
    for (int k = 0; k < 4; k++) begin
      logic [1:0] sk;
      sk = 2'(k);
      {w_s1, w_s0} = sk;
      @(posedge clk); #1;
      n_tests++;
      if (w_r !== words[k]) begin n_fail++; $display("FAIL wide sel=%0d r=%h exp=%h", k, w_r, words[k]); end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 200; n++) begin
      logic [7:0] words [4];
      logic [3:0] bits;
      int sel, sel8;
      for (int j = 0; j < 4; j++) words[j] = 8'($urandom);
      bits = 4'($urandom);
      sel = $urandom_range(3);
      sel8 = $urandom_range(3);
      {s1, s0} = 2'(sel);
      {i3, i2, i1, i0} = bits;
      {w_s1, w_s0} = 2'(sel8);
      w_i0 = words[0]; w_i1 = words[1]; w_i2 = words[2]; w_i3 = words[3];
      @(posedge clk); #1;
      n_tests++;
      if (r !== bits[sel]) begin n_fail++; $display("FAIL b2b_w1 n=%0d r=%b exp=%b", n, r, bits[sel]); end
      n_tests++;
      if (w_r !== words[sel8]) begin n_fail++; $display("FAIL b2b_w8 n=%0d r=%h exp=%h", n, w_r, words[sel8]); end
    end
  endtask

  initial begin
    test_reset();
    test_walking();
    test_unselected();
    test_exhaustive();
    test_mid_reset();
    test_wide();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_4x1.md
Name: mux_4x1

Overview:
- 4-to-1 selector, one output register stage; ALU building block.
- Two select bits pick one of four data inputs; the choice is registered on the clock.
- Output is reset asynchronously to zero.
- Used bit-sliced (WIDTH=1) or as a word-wide mux.

Parameters:
- WIDTH, 1, bit width of each data input and of the result.

Ports:
- clk  input  1  system clock; rising edge active.
- rst_n  input  1  asynchronous reset, active low.
- s0  input  1  select bit, LSB.
- s1  input  1  select bit, MSB.
- i0  input  WIDTH  data input, selected when {s1,s0}=00.
- i1  input  WIDTH  data input, selected when {s1,s0}=01.
- i2  input  WIDTH  data input, selected when {s1,s0}=10.
- i3  input  WIDTH  data input, selected when {s1,s0}=11.
- r  output  WIDTH  registered selected data.
- Positional order after clk, rst_n: s0, s1, i0, i1, i2, i3, r.

Behaviour:
- Select index sel = {s1,s0}.
  - 00 -> i0
  - 01 -> i1
  - 10 -> i2
  - 11 -> i3
- Selection logic is purely combinational; no priority between inputs.
- Unselected inputs have no effect on r.
- Register: on each rising clk edge with rst_n=1, r <= selected input.
- Latency: exactly 1 clock from select/data change to r.
- No enable; r updates every cycle.
- Reset:
  - rst_n=0 forces r to all zeros immediately, independent of clk.
  - r holds zero while rst_n=0.
  - The first rising edge after rst_n returns high captures the current selection.
- Reset asserted mid-operation: r clears at once; the previous value is lost.
- Simultaneous select and data change before an edge: the edge captures the new select with the new data.
- X/Z on s0 or s1: r is unspecified for that cycle. The bench must not rely on it.
- Width rule: all data inputs and r are WIDTH bits; no extension or truncation.
- Registered result is bit-exact to the combinational selection; no arithmetic.

Test Plan:
- Reset: hold rst_n=0 and drive i0=1, s1s0=00 with clk toggling -> r=0 throughout. Release rst_n; next rising edge -> r=1.
- Walking select (WIDTH=1), one-hot data matching select:
  - s1s0=00, i0..i3=1,0,0,0 -> r=1 one cycle later
  - s1s0=01, i0..i3=0,1,0,0 -> r=1
  - s1s0=10, i0..i3=0,0,1,0 -> r=1
  - s1s0=11, i0..i3=0,0,0,1 -> r=1
- Non-selected input: data held at i3=1, others 0. Change s1s0 from 11 to 10 -> r=0 one cycle later.
- Exhaustive check: all 64 combinations of {s1,s0,i0..i3} -> r equals i[{s1,s0}] one cycle after each is applied.
- Mid-operation reset: r=1 with s1s0=11, i3=1. Pulse rst_n low between clock edges -> r drops to 0 immediately. r returns to 1 on the first edge after release.
- Wide word (WIDTH=8): i0=8'hA5, i1=8'h3C, i2=8'hFF, i3=8'h00. Sweep s1s0 00..11 -> r = A5, 3C, FF, 00, each one cycle after its select.
